// File: rtl/sram_uart_transmitter_if.sv
// Host/SRAM-side bus of the SRAM-to-UART transmitter: transfer request,
// status and the read-only SRAM_controller port.
`timescale 1ns/1ps
interface sram_uart_transmitter_if #(
  parameter int ADDR_W = 18
);
  logic              Start;
  logic [ADDR_W-1:0] Start_address;
  logic [ADDR_W-1:0] Word_count;
  logic              Busy;
  logic              Done;
  logic [ADDR_W-1:0] SRAM_address;
  logic [15:0]       SRAM_read_data;
  logic              SRAM_we_n;

  modport master (
    output Start, Start_address, Word_count, SRAM_read_data,
    input  Busy, Done, SRAM_address, SRAM_we_n
  );

  modport slave (
    input  Start, Start_address, Word_count, SRAM_read_data,
    output Busy, Done, SRAM_address, SRAM_we_n
  );
endinterface

// File: rtl/sram_uart_transmitter.sv
// Streams a block of 16-bit SRAM words out of an 8N1 UART line, high byte
// first, fetching each word over a 2-cycle-latency SRAM read port.
//
// state          | meaning
// S_TX_IDLE      | waiting for Start; line idle high
// S_TX_RD_ISSUE  | word address presented to SRAM
// S_TX_RD_WAIT   | SRAM latency cycle
// S_TX_RD_LATCH  | read data captured into word register
// S_TX_START_BIT | line low for one bit time
// S_TX_DATA_BITS | 8 data bits, LSB first
// S_TX_STOP_BIT  | line high; then low byte or S_TX_NEXT
// S_TX_NEXT      | advance address/count; finish or fetch next word
`timescale 1ns/1ps
module sram_uart_transmitter #(
  parameter int CLKS_PER_BIT = 434,
  parameter int ADDR_W       = 18
) (
  input  logic                        CLOCK_50_I,
  input  logic                        resetn,
  sram_uart_transmitter_if.slave      bus,
  output logic                        UART_TX_O
);

  typedef enum logic [2:0] {
    S_TX_IDLE,
    S_TX_RD_ISSUE,
    S_TX_RD_WAIT,
    S_TX_RD_LATCH,
    S_TX_START_BIT,
    S_TX_DATA_BITS,
    S_TX_STOP_BIT,
    S_TX_NEXT
  } state_t;

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [15:0]       word_q, word_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic              hi_q, hi_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [7:0]        byte_sel;

  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_TX_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      word_q  <= '0;
      baud_q  <= '0;
      bit_q   <= '0;
      hi_q    <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      hi_q    <= hi_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    hi_d    = hi_q;
    case (state_q)
      S_TX_IDLE: begin
        if (bus.Start) begin
          addr_d = bus.Start_address;
          cnt_d  = bus.Word_count;
          if (bus.Word_count != '0) state_d = S_TX_RD_ISSUE;
        end
      end
      S_TX_RD_ISSUE: state_d = S_TX_RD_WAIT;
      S_TX_RD_WAIT:  state_d = S_TX_RD_LATCH;
      S_TX_RD_LATCH: begin
        word_d  = bus.SRAM_read_data;
        hi_d    = 1'b1;
        baud_d  = '0;
        state_d = S_TX_START_BIT;
      end
      S_TX_START_BIT: begin
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = S_TX_DATA_BITS;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_TX_DATA_BITS: begin
        if (baud_q == BAUD_LAST) begin
          baud_d = '0;
          if (bit_q == 3'd7) state_d = S_TX_STOP_BIT;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_TX_STOP_BIT: begin
        if (baud_q == BAUD_LAST) begin
          baud_d = '0;
          // high byte just finished: low byte follows with no idle gap
          if (hi_q) begin
            hi_d    = 1'b0;
            state_d = S_TX_START_BIT;
          end else begin
            state_d = S_TX_NEXT;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_TX_NEXT: begin
        addr_d  = addr_q + 1'b1;
        cnt_d   = cnt_q - 1'b1;
        state_d = (cnt_d == '0) ? S_TX_IDLE : S_TX_RD_ISSUE;
      end
      default: state_d = S_TX_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registered line and
  // flags change on the same edge as the state they belong to.
  always_comb begin
    byte_sel = hi_d ? word_q[15:8] : word_q[7:0];
    tx_d     = 1'b1;
    case (state_d)
      S_TX_START_BIT: tx_d = 1'b0;
      S_TX_DATA_BITS: tx_d = byte_sel[bit_d];
      default:        tx_d = 1'b1;
    endcase
    busy_d = (state_d != S_TX_IDLE);
    done_d = ((state_q == S_TX_NEXT) && (state_d == S_TX_IDLE)) ||
             ((state_q == S_TX_IDLE) && bus.Start && (bus.Word_count == '0));
  end

  assign bus.SRAM_address = addr_q;
  assign bus.SRAM_we_n    = 1'b1;
  assign bus.Busy         = busy_q;
  assign bus.Done         = done_q;
  assign UART_TX_O        = tx_q;

endmodule

// File: tb/tb_sram_uart_transmitter.sv
// Directed bench: one transmitter at the 115200-baud divider and one at a
// 4-cycle divider, each fed by a 2-cycle-latency SRAM model.
`timescale 1ns/1ps
module tb_sram_uart_transmitter;
  localparam int AW = 18;

  logic clk = 1'b0;
  logic resetn = 1'b1;
  always #5 clk = ~clk;

  sram_uart_transmitter_if #(.ADDR_W(AW)) bus_a ();
  sram_uart_transmitter_if #(.ADDR_W(AW)) bus_b ();
  logic tx_a, tx_b;

  sram_uart_transmitter #(.CLKS_PER_BIT(434), .ADDR_W(AW)) dut_a (
    .CLOCK_50_I(clk), .resetn(resetn), .bus(bus_a.slave), .UART_TX_O(tx_a));
  sram_uart_transmitter #(.CLKS_PER_BIT(4), .ADDR_W(AW)) dut_b (
    .CLOCK_50_I(clk), .resetn(resetn), .bus(bus_b.slave), .UART_TX_O(tx_b));

  int checks = 0;
  int errors = 0;
  int dc_a = 0;
  int dc_b = 0;
  logic [15:0] d1_a, d1_b;

  function automatic logic [15:0] mem_val(input logic [AW-1:0] a);
    case (a)
      18'd0:      return 16'hA55A;
      18'd1:      return 16'h00FF;
      18'd262143: return 16'h1234;
      default:    return {a[7:0], ~a[7:0]};
    endcase
  endfunction

  always @(posedge clk) begin
    d1_a <= mem_val(bus_a.SRAM_address);
    bus_a.SRAM_read_data <= d1_a;
    d1_b <= mem_val(bus_b.SRAM_address);
    bus_b.SRAM_read_data <= d1_b;
    if (bus_a.Done === 1'b1) dc_a <= dc_a + 1;
    if (bus_b.Done === 1'b1) dc_b <= dc_b + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_frame(input bit use_b, input logic [7:0] b, input string tag);
    logic [9:0] bits;
    int cpb;
    int bad;
    logic t;
    bits = {1'b1, b, 1'b0};
    cpb  = use_b ? 4 : 434;
    for (int i = 0; i < 10; i++) begin
      bad = 0;
      for (int c = 0; c < cpb; c++) begin
        t = use_b ? tx_b : tx_a;
        if (t !== bits[i]) bad++;
        step();
      end
      chk($sformatf("%s bit%0d bad_cycles", tag, i), bad, 0);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int base;
    int n;
    bus_a.Start = 1'b0; bus_a.Start_address = '0; bus_a.Word_count = '0;
    bus_b.Start = 1'b0; bus_b.Start_address = '0; bus_b.Word_count = '0;

    // reset values
    #1 resetn = 1'b0;
    #2;
    chk("rst tx_a", tx_a, 1);
    chk("rst busy_a", bus_a.Busy, 0);
    chk("rst done_a", bus_a.Done, 0);
    chk("rst addr_a", bus_a.SRAM_address, 0);
    chk("rst we_n_a", bus_a.SRAM_we_n, 1);
    chk("rst tx_b", tx_b, 1);
    chk("rst busy_b", bus_b.Busy, 0);
    chk("rst addr_b", bus_b.SRAM_address, 0);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    step();

    // zero word count: Done only, line and Busy untouched
    bus_a.Start_address = 18'd7; bus_a.Word_count = '0; bus_a.Start = 1'b1;
    step();
    bus_a.Start = 1'b0;
    chk("wc0 done", bus_a.Done, 1);
    chk("wc0 busy", bus_a.Busy, 0);
    chk("wc0 tx", tx_a, 1);
    step();
    chk("wc0 done drop", bus_a.Done, 0);
    chk("wc0 busy after", bus_a.Busy, 0);
    chk("wc0 tx after", tx_a, 1);

    // one word A55A at 434 clocks per bit; inputs scrambled after accept
    base = dc_a;
    bus_a.Start_address = 18'd0; bus_a.Word_count = 18'd1; bus_a.Start = 1'b1;
    step();
    bus_a.Start = 1'b0; bus_a.Start_address = 18'd5; bus_a.Word_count = 18'd9;
    chk("A busy N+1", bus_a.Busy, 1);
    chk("A addr", bus_a.SRAM_address, 0);
    chk("A tx N+1", tx_a, 1);
    step();
    chk("A tx N+2", tx_a, 1);
    step();
    chk("A tx N+3", tx_a, 1);
    step();
    check_frame(1'b0, 8'hA5, "A hi");
    check_frame(1'b0, 8'h5A, "A lo");
    chk("A next tx", tx_a, 1);
    chk("A next busy", bus_a.Busy, 1);
    chk("A next done", bus_a.Done, 0);
    step();
    chk("A done", bus_a.Done, 1);
    chk("A busy drop", bus_a.Busy, 0);
    step();
    chk("A done pulse", bus_a.Done, 0);
    chk("A done count", dc_a - base, 1);

    // address wrap, two words, Start re-asserted mid-transfer
    base = dc_b;
    bus_b.Start_address = 18'h3FFFF; bus_b.Word_count = 18'd2; bus_b.Start = 1'b1;
    step();
    bus_b.Start = 1'b0; bus_b.Start_address = 18'h100; bus_b.Word_count = '0;
    chk("C addr first", bus_b.SRAM_address, 18'h3FFFF);
    chk("C busy", bus_b.Busy, 1);
    step(); step(); step();
    check_frame(1'b1, 8'h12, "C w0 hi");
    bus_b.Start = 1'b1;
    check_frame(1'b1, 8'h34, "C w0 lo");
    bus_b.Start = 1'b0;
    chk("C addr held", bus_b.SRAM_address, 18'h3FFFF);
    chk("C gap tx", tx_b, 1);
    chk("C gap busy", bus_b.Busy, 1);
    step();
    chk("C addr wrapped", bus_b.SRAM_address, 0);
    chk("C gap tx2", tx_b, 1);
    step(); step(); step();
    check_frame(1'b1, 8'hA5, "C w1 hi");
    check_frame(1'b1, 8'h5A, "C w1 lo");
    chk("C next busy", bus_b.Busy, 1);
    step();
    chk("C done", bus_b.Done, 1);
    chk("C busy drop", bus_b.Busy, 0);
    step();
    chk("C done count", dc_b - base, 1);

    // three words at 4 clocks per bit: Busy length
    base = dc_b;
    bus_b.Start_address = 18'd5; bus_b.Word_count = 18'd3; bus_b.Start = 1'b1;
    step();
    bus_b.Start = 1'b0;
    n = 0;
    while (bus_b.Busy === 1'b1 && n < 2000) begin
      n++;
      step();
    end
    chk("D busy cycles", n, 3 * 84);
    chk("D done with busy drop", bus_b.Done, 1);
    step();
    chk("D done count", dc_b - base, 1);

    // reset during a data bit, then a clean transfer
    base = dc_b;
    bus_b.Start_address = 18'd0; bus_b.Word_count = 18'd1; bus_b.Start = 1'b1;
    step();
    bus_b.Start = 1'b0;
    step(); step(); step();
    repeat (8) step();
    chk("E data bit1", tx_b, 0);
    #2 resetn = 1'b0;
    #1;
    chk("E async tx", tx_b, 1);
    chk("E async busy", bus_b.Busy, 0);
    repeat (3) step();
    resetn = 1'b1;
    repeat (20) step();
    chk("E no done", dc_b - base, 0);
    chk("E idle tx", tx_b, 1);
    chk("E idle busy", bus_b.Busy, 0);
    bus_b.Start_address = 18'd1; bus_b.Word_count = 18'd1; bus_b.Start = 1'b1;
    step();
    bus_b.Start = 1'b0;
    chk("E2 busy", bus_b.Busy, 1);
    step(); step(); step();
    check_frame(1'b1, 8'h00, "E2 hi");
    check_frame(1'b1, 8'hFF, "E2 lo");
    chk("E2 next busy", bus_b.Busy, 1);
    step();
    chk("E2 done", bus_b.Done, 1);
    step();
    chk("E2 done count", dc_b - base, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
